// File: rtl/sn7408_tester.sv
// Test sequencer for an SN7408 quad AND model: powers the part, walks four
// input vectors through every gate and reports a per-gate pass/fail mask.
module sn7408_tester #(
    parameter int unsigned PWR_UP = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    output logic       dut_vcc,
    output logic       dut_gnd,
    output logic [3:0] dut_a,
    output logic [3:0] dut_b,
    input  logic [3:0] dut_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask
);

    localparam int unsigned GATES = 4;
    localparam int unsigned VEC_W = 2;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POWER,
        S_APPLY,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   v_q, v_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               vcc_d, busy_d, done_d, pass_d;
    logic [GATES-1:0]   a_d, b_d, mask_d, fail_now;
    logic               run_state;

    // Gate i sees combination (v+i) mod 4: a = bit 0, b = bit 1.
    function automatic logic [2*GATES-1:0] vec_drive(input logic [VEC_W-1:0] v);
        logic [GATES-1:0] a;
        logic [GATES-1:0] b;
        logic [VEC_W-1:0] u;
        for (int unsigned i = 0; i < GATES; i++) begin
            u    = v + VEC_W'(i);
            a[i] = u[0];
            b[i] = u[1];
        end
        return {b, a};
    endfunction

    assign dut_gnd = 1'b0;

    // X or Z on a gate output is a mismatch as well
    always_comb begin
        fail_now = '0;
        for (int unsigned i = 0; i < GATES; i++) begin
            fail_now[i] = (dut_y[i] !== (dut_a[i] & dut_b[i]));
        end
    end

    always_comb begin
        state_d   = state_q;
        v_d       = v_q;
        cnt_d     = cnt_q;
        mask_d    = fail_mask;
        pass_d    = pass;
        a_d       = dut_a;
        b_d       = dut_b;
        run_state = (state_q == S_POWER) || (state_q == S_APPLY) ||
                    (state_q == S_SETTLE) || (state_q == S_CHECK);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_d  = '0;
                    pass_d  = 1'b0;
                    v_d     = '0;
                    cnt_d   = CNT_W'(PWR_UP - 1);
                    state_d = S_POWER;
                end
            end
            S_POWER: begin
                if (cnt_q == '0) state_d = S_APPLY;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_APPLY: begin
                cnt_d   = CNT_W'(SETTLE - 1);
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == '0) state_d = S_CHECK;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_CHECK: begin
                mask_d = fail_mask | fail_now;
                if (v_q == VEC_W'(GATES - 1)) begin
                    pass_d  = (mask_d == '0);
                    state_d = S_DONE;
                end else begin
                    v_d     = v_q + 1'b1;
                    state_d = S_APPLY;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort && run_state) begin
            state_d = S_IDLE;
            mask_d  = '1;
            pass_d  = 1'b0;
        end

        // Pin drive follows the state being entered so it is valid in that cycle
        if (state_d == S_APPLY) begin
            {b_d, a_d} = vec_drive(v_d);
        end else if (state_d == S_IDLE || state_d == S_POWER || state_d == S_DONE) begin
            a_d = '0;
            b_d = '0;
        end

        vcc_d  = (state_d == S_POWER) || (state_d == S_APPLY) ||
                 (state_d == S_SETTLE) || (state_d == S_CHECK);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            v_q       <= '0;
            cnt_q     <= '0;
            dut_vcc   <= 1'b0;
            dut_a     <= '0;
            dut_b     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= '0;
        end else begin
            state_q   <= state_d;
            v_q       <= v_d;
            cnt_q     <= cnt_d;
            dut_vcc   <= vcc_d;
            dut_a     <= a_d;
            dut_b     <= b_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
            fail_mask <= mask_d;
        end
    end

endmodule

// File: tb/tb_sn7408_tester.sv
// Bench for sn7408_tester: timeline reference model compared every cycle,
// directed scenarios with literal expectations, then randomized runs.
module tb_sn7408_tester;

    localparam int P = 4;
    localparam int S = 2;
    localparam int T = P + 4 * (S + 2) + 1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       dut_vcc, dut_gnd, busy, done, pass;
    logic [3:0] dut_a, dut_b, dut_y, fail_mask;

    logic       start2 = 1'b0;
    logic       vcc2, gnd2, busy2, done2, pass2;
    logic [3:0] a2, b2, y2, mask2;

    // Attached part: good AND gates with optional stuck-at faults, X or random outputs
    int         ymode = 0;
    logic [3:0] s1 = 4'h0;
    logic [3:0] s0 = 4'h0;
    logic [3:0] y_rand = 4'h0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign dut_y = (ymode == 2) ? 4'bxxxx :
                   (ymode == 3) ? y_rand  : (((dut_a & dut_b) | s1) & ~s0);
    assign y2    = a2 & b2;

    sn7408_tester #(.PWR_UP(P), .SETTLE(S)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .dut_vcc(dut_vcc), .dut_gnd(dut_gnd), .dut_a(dut_a), .dut_b(dut_b),
        .dut_y(dut_y), .busy(busy), .done(done), .pass(pass), .fail_mask(fail_mask)
    );

    sn7408_tester #(.PWR_UP(1), .SETTLE(1)) u_dut_fast (
        .clk(clk), .reset_n(reset_n), .start(start2), .abort(1'b0),
        .dut_vcc(vcc2), .dut_gnd(gnd2), .dut_a(a2), .dut_b(b2),
        .dut_y(y2), .busy(busy2), .done(done2), .pass(pass2), .fail_mask(mask2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a run is a timeline of T cycles numbered 1..T after the start edge
    bit         m_active = 1'b0;
    int         m_k = 0;
    logic [3:0] m_mask = 4'h0;
    logic       m_pass = 1'b0;

    function automatic logic [3:0] pat(input int vec, input int sel);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i] = 1'(((vec + i) % 4 >> sel) & 1);
        end
        return r;
    endfunction

    function automatic bit drive_cycle(input int k);
        return (k > P) && (k < T);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 1'b0;
            m_k      = 0;
            m_mask   = 4'h0;
            m_pass   = 1'b0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1;
                m_k      = 1;
                m_mask   = 4'h0;
                m_pass   = 1'b0;
            end
        end else if (m_k < T && abort) begin
            m_active = 1'b0;
            m_mask   = 4'hF;
            m_pass   = 1'b0;
        end else if (m_k == T) begin
            m_active = 1'b0;
        end else begin
            if (drive_cycle(m_k) && ((m_k - P - 1) % (S + 2)) == S + 1) begin
                logic [3:0] ab, y;
                ab = pat((m_k - P - 1) / (S + 2), 0) & pat((m_k - P - 1) / (S + 2), 1);
                y  = (ab | s1) & ~s0;
                m_mask = (ymode == 2) ? 4'hF : (m_mask | (y ^ ab));
            end
            m_k++;
            if (m_k == T) m_pass = (m_mask == 4'h0);
        end
    end

    always @(negedge clk) begin
        logic [3:0] ea, eb;
        ea = 4'h0;
        eb = 4'h0;
        if (m_active && drive_cycle(m_k)) begin
            ea = pat((m_k - P - 1) / (S + 2), 0);
            eb = pat((m_k - P - 1) / (S + 2), 1);
        end
        chk("busy",    32'(busy),    32'(m_active));
        chk("done",    32'(done),    32'(m_active && m_k == T));
        chk("dut_vcc", 32'(dut_vcc), 32'(m_active && m_k < T));
        chk("dut_gnd", 32'(dut_gnd), 32'd0);
        chk("dut_a",   32'(dut_a),   32'(ea));
        chk("dut_b",   32'(dut_b),   32'(eb));
        chk("pass",    32'(pass),    32'(m_pass));
        if (!(ymode == 2 && m_active)) chk("fail_mask", 32'(fail_mask), 32'(m_mask));
    end

    logic [3:0] seq_a[4];
    logic [3:0] seq_b[4];
    int         seq_n;

    // One run on the default instance; optional start pokes, abort and reset cycles
    task automatic run_test(input int abort_k, input bit poke, input int rst_k,
                            output int busy_n, output int done_n);
        logic [3:0] pa, pb;
        pa = 4'h0; pb = 4'h0; seq_n = 0;
        busy_n = 0; done_n = 0;
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            start = 1'b0;
            abort = 1'b0;
            if (k == rst_k) begin
                reset_n = 1'b0;
                #1;
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_vcc",  32'(dut_vcc), 32'd0);
                chk("rst_a",    32'(dut_a), 32'd0);
                chk("rst_mask", 32'(fail_mask), 32'd0);
                break;
            end
            if (!busy && k > 1) break;
            if (busy) busy_n++;
            if (done) done_n++;
            if (dut_vcc && (dut_a | dut_b) != 4'h0 && (dut_a != pa || dut_b != pb)) begin
                if (seq_n < 4) begin
                    seq_a[seq_n] = dut_a;
                    seq_b[seq_n] = dut_b;
                end
                seq_n++;
                pa = dut_a;
                pb = dut_b;
            end
            if (poke && (k == 6 || k == T)) start = 1'b1;
            if (k == abort_k) abort = 1'b1;
            @(posedge clk); #2;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int bn, dn;
        logic [3:0] ra[4];
        logic [3:0] rb[4];
        // Vector v drives gate i with (v+i) mod 4
        ra[0] = 4'b1010; rb[0] = 4'b1100;
        ra[1] = 4'b0101; rb[1] = 4'b0110;
        ra[2] = 4'b1010; rb[2] = 4'b0011;
        ra[3] = 4'b0101; rb[3] = 4'b1001;

        // Reset held with random start and gate outputs
        ymode = 3;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #2;
            start  = 1'($urandom_range(0, 1));
            y_rand = 4'($urandom_range(0, 15));
        end
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_mask", 32'(fail_mask), 32'd0);
        start = 1'b0;
        ymode = 0;
        @(posedge clk); #2 reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #2 chk("idle_busy", 32'(busy), 32'd0);

        // Good part, defaults
        run_test(0, 1'b0, 0, bn, dn);
        chk("good_busy_cycles", 32'(bn), 32'd21);
        chk("good_done_count", 32'(dn), 32'd1);
        chk("good_pass", 32'(pass), 32'd1);
        chk("good_mask", 32'(fail_mask), 32'h0);
        chk("good_vec_count", 32'(seq_n), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("vec%0d_a", i), 32'(seq_a[i]), 32'(ra[i]));
            chk($sformatf("vec%0d_b", i), 32'(seq_b[i]), 32'(rb[i]));
        end

        // Stuck-at faults
        s1 = 4'b0100;
        run_test(0, 1'b0, 0, bn, dn);
        chk("sa1_g2_mask", 32'(fail_mask), 32'b0100);
        chk("sa1_g2_pass", 32'(pass), 32'd0);
        s1 = 4'h0; s0 = 4'b0001;
        run_test(0, 1'b0, 0, bn, dn);
        chk("sa0_g0_mask", 32'(fail_mask), 32'b0001);
        s0 = 4'h0;

        // Unknown outputs fail every gate
        ymode = 2;
        run_test(0, 1'b0, 0, bn, dn);
        chk("x_mask", 32'(fail_mask), 32'hF);
        chk("x_pass", 32'(pass), 32'd0);
        ymode = 0;

        // Short timing on the fast instance
        @(posedge clk); #2 start2 = 1'b1;
        @(posedge clk); #2 start2 = 1'b0;
        bn = 0; dn = 0;
        for (int k = 1; k <= 40; k++) begin
            if (!busy2) break;
            bn++;
            if (done2) dn++;
            if (k == 3) begin
                chk("fast_vcc", 32'(vcc2), 32'd1);
                chk("fast_gnd", 32'(gnd2), 32'd0);
            end
            @(posedge clk); #2;
        end
        chk("fast_busy_cycles", 32'(bn), 32'd14);
        chk("fast_done_count", 32'(dn), 32'd1);
        chk("fast_pass", 32'(pass2), 32'd1);
        chk("fast_mask", 32'(mask2), 32'h0);

        // Start pokes during SETTLE and DONE are ignored
        run_test(0, 1'b1, 0, bn, dn);
        chk("poke_busy_cycles", 32'(bn), 32'd21);
        chk("poke_done_count", 32'(dn), 32'd1);
        chk("poke_pass", 32'(pass), 32'd1);

        // Abort in vector 1 SETTLE
        run_test(10, 1'b0, 0, bn, dn);
        chk("abort_busy_cycles", 32'(bn), 32'd10);
        chk("abort_done_count", 32'(dn), 32'd0);
        chk("abort_vcc", 32'(dut_vcc), 32'd0);
        chk("abort_mask", 32'(fail_mask), 32'hF);
        chk("abort_pass", 32'(pass), 32'd0);

        // Reset during vector 2 CHECK, then a clean run
        run_test(0, 1'b0, 16, bn, dn);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        run_test(0, 1'b0, 0, bn, dn);
        chk("rerun_busy_cycles", 32'(bn), 32'd21);
        chk("rerun_pass", 32'(pass), 32'd1);

        // Randomized runs against the reference model
        for (int r = 0; r < 16; r++) begin
            int sel, ak;
            sel = int'($urandom_range(0, 3));
            ymode = (sel == 3) ? 2 : 0;
            s1 = (sel == 1) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
            s0 = (sel == 2) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
            ak = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, T + 1)) : 0;
            run_test(ak, 1'($urandom_range(0, 1)), 0, bn, dn);
            repeat (int'($urandom_range(0, 2))) @(posedge clk);
        end
        ymode = 0; s1 = 4'h0; s0 = 4'h0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
